// File: rtl/router_1x3_if.sv
// router_1x3_if: byte stream in, three FIFO read ports out, plus busy/err status.
// master = packet source / reader side, slave = router side.
interface router_1x3_if #(
    parameter int WIDTH = 8
);
    logic             pkt_valid;
    logic [WIDTH-1:0] data_in;
    logic             read_enb_0;
    logic             read_enb_1;
    logic             read_enb_2;
    logic [WIDTH-1:0] data_out_0;
    logic [WIDTH-1:0] data_out_1;
    logic [WIDTH-1:0] data_out_2;
    logic             vld_out_0;
    logic             vld_out_1;
    logic             vld_out_2;
    logic             busy;
    logic             err;

    modport master (
        output pkt_valid, data_in, read_enb_0, read_enb_1, read_enb_2,
        input  data_out_0, data_out_1, data_out_2,
        input  vld_out_0, vld_out_1, vld_out_2, busy, err
    );

    modport slave (
        input  pkt_valid, data_in, read_enb_0, read_enb_1, read_enb_2,
        output data_out_0, data_out_1, data_out_2,
        output vld_out_0, vld_out_1, vld_out_2, busy, err
    );
endinterface

// File: rtl/router_1x3.sv
// router_1x3: single-input byte packet router steering packets by header address
// into three independent output FIFOs, with XOR parity check on each packet.
// Optional unread-timeout flush per FIFO when ROUTER_SOFT_RESET_EN is defined.
//
// state           | meaning
// ----------------+--------------------------------------------------------
// DECODE          | idle, sample header byte and pick destination
// WAIT_EMPTY      | header held, waiting for destination FIFO to drain
// LOAD_FIRST      | write header, clear err, seed running parity
// LOAD_DATA       | accept payload bytes; parity byte ends the packet
// FULL            | destination full, one payload byte held
// LOAD_AFTER_FULL | write the held byte once a slot frees up
// LOAD_PARITY     | write the received parity byte
// CHECK_PARITY    | compare received vs running parity into err
module router_1x3 #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic        clock,
    input  logic        resetn,
    router_1x3_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef ROUTER_SOFT_RESET_EN
    localparam bit SOFT_RESET = 1'b1;
`else
    localparam bit SOFT_RESET = 1'b0;
`endif

    typedef enum logic [2:0] {
        DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA,
        FULL, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY
    } state_t;

    state_t state, state_nxt;

    logic [1:0]         addr_q;
    logic [WIDTH-1:0]   hdr_q, hold_q, rx_par_q, run_par_q;
    logic               err_q;

    logic [2:0]         rd_req, pop, push, empty, full, flush;
    logic [3*WIDTH-1:0] dout_all;

    logic               busy, wr_en, wr_hdr, serve_flush, decode_hit;
    logic [WIDTH-1:0]   wr_data;
    logic [1:0]         in_addr;

    // addr 3 never reaches a FIFO, so it reads as "not set" for any flag vector
    function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
        case (a)
            2'd0:    pick = v[0];
            2'd1:    pick = v[1];
            2'd2:    pick = v[2];
            default: pick = 1'b0;
        endcase
    endfunction

    assign in_addr     = bus.data_in[1:0];
    assign rd_req      = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    assign decode_hit  = (state == DECODE) && bus.pkt_valid && (in_addr != 2'd3);
    // WAIT_EMPTY is not aborted: its header was already taken from the source
    assign serve_flush = pick(flush, addr_q) && (state inside {LOAD_FIRST, LOAD_DATA,
                         FULL, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY});

    // FSM state register
    always_ff @(posedge clock) begin
        if (resetn) state <= DECODE;
        else        state <= state_nxt;
    end

    // next state, busy and FIFO write controls
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        wr_en     = 1'b0;
        wr_hdr    = 1'b0;
        wr_data   = bus.data_in;
        case (state)
            DECODE: begin
                busy = 1'b0;
                if (decode_hit)
                    state_nxt = pick(empty, in_addr) ? LOAD_FIRST : WAIT_EMPTY;
            end
            WAIT_EMPTY: begin
                if (pick(empty, addr_q)) state_nxt = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                wr_en     = 1'b1;
                wr_hdr    = 1'b1;
                wr_data   = hdr_q;
                state_nxt = LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = 1'b0;
                if (!bus.pkt_valid)
                    state_nxt = LOAD_PARITY;
                else if (pick(full, addr_q) && !pick(pop, addr_q))
                    state_nxt = FULL;
                else
                    wr_en = 1'b1;
            end
            FULL: begin
                if (!pick(full, addr_q)) state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                wr_en     = 1'b1;
                wr_data   = hold_q;
                state_nxt = bus.pkt_valid ? LOAD_DATA : LOAD_PARITY;
            end
            LOAD_PARITY: begin
                // a reader may have left the FIFO full after the held byte went in
                wr_data = rx_par_q;
                if (!pick(full, addr_q) || pick(pop, addr_q)) begin
                    wr_en     = 1'b1;
                    state_nxt = CHECK_PARITY;
                end
            end
            CHECK_PARITY: state_nxt = DECODE;
            default:      state_nxt = DECODE;
        endcase
        if (serve_flush) begin
            wr_en     = 1'b0;
            state_nxt = DECODE;
        end
    end

    // header capture, held byte, parity tracking and err
    always_ff @(posedge clock) begin
        if (resetn) begin
            addr_q    <= '0;
            hdr_q     <= '0;
            hold_q    <= '0;
            rx_par_q  <= '0;
            run_par_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (decode_hit) begin
                hdr_q  <= bus.data_in;
                addr_q <= in_addr;
            end
            case (state)
                LOAD_FIRST: begin
                    err_q     <= 1'b0;
                    run_par_q <= hdr_q;
                end
                LOAD_DATA: begin
                    if (!bus.pkt_valid)  rx_par_q  <= bus.data_in;
                    else if (wr_en)      run_par_q <= run_par_q ^ bus.data_in;
                    else                 hold_q    <= bus.data_in;
                end
                LOAD_AFTER_FULL: begin
                    // source has been held by busy, so data_in is its next byte
                    run_par_q <= run_par_q ^ hold_q;
                    if (!bus.pkt_valid) rx_par_q <= bus.data_in;
                end
                CHECK_PARITY: begin
                    if (!serve_flush) err_q <= (rx_par_q != run_par_q);
                end
                default: ;
            endcase
        end
    end

    for (genvar n = 0; n < 3; n++) begin : g_fifo
        logic [WIDTH:0]   mem [DEPTH];
        logic [PW-1:0]    wr_ptr, rd_ptr;
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] dout_q;
        logic [TW-1:0]    tmr;
        logic             stale;

        assign empty[n] = (count == '0);
        assign full[n]  = (count == CW'(DEPTH));
        assign pop[n]   = rd_req[n] && !empty[n];
        assign push[n]  = wr_en && (addr_q == 2'(n));
        assign stale    = !empty[n] && !rd_req[n];
        assign flush[n] = SOFT_RESET && stale && (tmr == '0);
        assign dout_all[n*WIDTH +: WIDTH] = dout_q;

        // storage; bit WIDTH tags the header entry
        always_ff @(posedge clock) begin
            if (push[n]) mem[wr_ptr] <= {wr_hdr, wr_data};
        end

        // pointers, occupancy count and registered read data
        always_ff @(posedge clock) begin
            if (resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                dout_q <= '0;
            end else if (flush[n]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[n]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[n]) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    dout_q <= mem[rd_ptr][WIDTH-1:0];
                end
                count <= count + CW'(push[n]) - CW'(pop[n]);
            end
        end

        // unread-timeout down-counter; terminal count on the TIMEOUT-th stale clock
        always_ff @(posedge clock) begin
            if (resetn || !stale || tmr == '0) tmr <= TW'(TIMEOUT - 1);
            else                               tmr <= tmr - TW'(1);
        end
    end

    assign bus.data_out_0 = dout_all[0*WIDTH +: WIDTH];
    assign bus.data_out_1 = dout_all[1*WIDTH +: WIDTH];
    assign bus.data_out_2 = dout_all[2*WIDTH +: WIDTH];
    assign bus.vld_out_0  = !empty[0];
    assign bus.vld_out_1  = !empty[1];
    assign bus.vld_out_2  = !empty[2];
    assign bus.busy       = busy;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_router_1x3.sv
// tb_router_1x3: directed packets through router_1x3 with hand-built expected byte streams.
module tb_router_1x3;
    typedef logic [7:0] byte_q_t[$];

    logic clock = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    router_1x3_if #(.WIDTH(8)) bus ();

    router_1x3 #(.DEPTH(16), .WIDTH(8), .TIMEOUT(30)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic vld(input int n);
        case (n)
            0:       return bus.vld_out_0;
            1:       return bus.vld_out_1;
            default: return bus.vld_out_2;
        endcase
    endfunction

    function automatic logic [7:0] dout(input int n);
        case (n)
            0:       return bus.data_out_0;
            1:       return bus.data_out_1;
            default: return bus.data_out_2;
        endcase
    endfunction

    task automatic set_rd(input int n, input logic v);
        case (n)
            0:       bus.read_enb_0 = v;
            1:       bus.read_enb_1 = v;
            default: bus.read_enb_2 = v;
        endcase
    endtask

    // header + payload + parity (XOR of all, optionally corrupted)
    function automatic byte_q_t make_pkt(input logic [1:0] addr, input byte_q_t pl,
                                         input logic [7:0] par_xor);
        byte_q_t    p;
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = {6'(pl.size()), addr};
        p.push_back(hdr);
        par = hdr;
        foreach (pl[i]) begin
            p.push_back(pl[i]);
            par = par ^ pl[i];
        end
        p.push_back(par ^ par_xor);
        return p;
    endfunction

    // last byte goes out with pkt_valid=0; each byte is held until busy=0 at a rising edge
    task automatic send_pkt(input byte_q_t p);
        int guard;
        for (int i = 0; i < p.size(); i++) begin
            guard = 0;
            @(negedge clock);
            bus.pkt_valid = (i != p.size() - 1);
            bus.data_in   = p[i];
            while (bus.busy && guard < 300) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 300) begin
                check("send_stall", bus.busy, 1'b0);
                break;
            end
            @(posedge clock);
        end
        @(negedge clock);
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
    endtask

    task automatic drain(input int n, input byte_q_t exp, input string tag);
        int guard;
        for (int i = 0; i < exp.size(); i++) begin
            guard = 0;
            @(negedge clock);
            while (!vld(n) && guard < 300) begin
                set_rd(n, 1'b0);
                @(negedge clock);
                guard++;
            end
            if (guard >= 300) begin
                check({tag, "_vld_timeout"}, vld(n), 1'b1);
                set_rd(n, 1'b0);
                return;
            end
            set_rd(n, 1'b1);
            @(posedge clock);
            #1;
            check($sformatf("%s[%0d]", tag, i), dout(n), exp[i]);
        end
        @(negedge clock);
        set_rd(n, 1'b0);
    endtask

    initial begin
        byte_q_t pkt, pkt_b, pl;

        bus.pkt_valid  = 1'b0;
        bus.data_in    = 8'h00;
        bus.read_enb_0 = 1'b0;
        bus.read_enb_1 = 1'b0;
        bus.read_enb_2 = 1'b0;
        resetn         = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);

        // reset state
        check("rst_busy",  bus.busy,       1'b0);
        check("rst_err",   bus.err,        1'b0);
        check("rst_vld0",  bus.vld_out_0,  1'b0);
        check("rst_vld1",  bus.vld_out_1,  1'b0);
        check("rst_vld2",  bus.vld_out_2,  1'b0);
        check("rst_dout0", bus.data_out_0, 8'h00);
        check("rst_dout1", bus.data_out_1, 8'h00);
        check("rst_dout2", bus.data_out_2, 8'h00);

        // header 0x16: L=5 to FIFO 2; parity hand-computed as 0x22
        pkt = '{8'h16, 8'hA5, 8'h3C, 8'h7E, 8'h01, 8'hD2, 8'h22};
        send_pkt(pkt);
        repeat (2) @(posedge clock);
        #1;
        check("p2_vld2", bus.vld_out_2, 1'b1);
        check("p2_vld0", bus.vld_out_0, 1'b0);
        check("p2_vld1", bus.vld_out_1, 1'b0);
        check("p2_err",  bus.err,       1'b0);
        drain(2, pkt, "p2");
        check("p2_vld2_empty", bus.vld_out_2,  1'b0);
        check("p2_dout0",      bus.data_out_0, 8'h00);
        check("p2_dout1",      bus.data_out_1, 8'h00);

        // L=14 to FIFO 1, parity corrupted
        pl = {};
        for (int i = 0; i < 14; i++) pl.push_back(8'(8'h30 + i * 7));
        pkt = make_pkt(2'd1, pl, 8'h01);
        send_pkt(pkt);
        repeat (2) @(posedge clock);
        #1;
        check("p3_err", bus.err, 1'b1);
        drain(1, pkt, "p3");
        check("p3_err_hold", bus.err, 1'b1);

        // next packet clears err at its header write, well before its own parity check
        pl  = '{8'h0F, 8'hF0, 8'h5A};
        pkt = make_pkt(2'd0, pl, 8'h00);
        fork
            send_pkt(pkt);
            begin
                repeat (4) @(posedge clock);
                #1;
                check("p3_err_clear", bus.err, 1'b0);
            end
        join
        drain(0, pkt, "p3b");
        check("p3b_err", bus.err, 1'b0);

        // L=16 to FIFO 0 with idle reader: header + 15 payload fill it, 16th byte stalls
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(8'hC1 ^ (i * 13)));
        pkt = make_pkt(2'd0, pl, 8'h00);
        fork
            send_pkt(pkt);
            begin
                repeat (22) @(negedge clock);
                check("p4_busy_full", bus.busy, 1'b1);
                check("p4_vld0",      bus.vld_out_0, 1'b1);
                repeat (2) @(negedge clock);
                check("p4_busy_hold", bus.busy, 1'b1);
                drain(0, pkt, "p4");
            end
        join
        repeat (2) @(negedge clock);
        check("p4_busy_done", bus.busy,      1'b0);
        check("p4_vld0_done", bus.vld_out_0, 1'b0);
        check("p4_err",       bus.err,       1'b0);

        // addr 3 header: whole packet ignored (payload bytes also carry addr 3)
        pkt = '{8'h0B, 8'h03, 8'h07, 8'h0F};
        send_pkt(pkt);
        repeat (3) @(negedge clock);
        check("p5_vld0", bus.vld_out_0, 1'b0);
        check("p5_vld1", bus.vld_out_1, 1'b0);
        check("p5_vld2", bus.vld_out_2, 1'b0);
        check("p5_busy", bus.busy,      1'b0);

        // second packet to FIFO 2 while first still unread
        pl    = '{8'h11, 8'h22, 8'h33};
        pkt   = make_pkt(2'd2, pl, 8'h00);
        pl    = '{8'h44, 8'h55, 8'h66, 8'h77};
        pkt_b = make_pkt(2'd2, pl, 8'h00);
        send_pkt(pkt);
        fork
            send_pkt(pkt_b);
            begin
                repeat (6) @(negedge clock);
                check("p6_wait_busy", bus.busy,      1'b1);
                check("p6_vld2",      bus.vld_out_2, 1'b1);
`ifdef ROUTER_SOFT_RESET_EN
                begin
                    int guard;
                    guard = 0;
                    while (bus.vld_out_2 && guard < 60) begin
                        @(negedge clock);
                        guard++;
                    end
                    check("p6_flush_vld2", bus.vld_out_2, 1'b0);
                end
`else
                drain(2, pkt,   "p6a");
                drain(2, pkt_b, "p6b");
`endif
            end
        join
`ifndef ROUTER_SOFT_RESET_EN
        repeat (2) @(negedge clock);
        check("p6_busy_done", bus.busy,      1'b0);
        check("p6_vld2_done", bus.vld_out_2, 1'b0);
        check("p6_err",       bus.err,       1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
